// File: rtl/regfile_pkg.sv
// Shared definitions for the MIPS lab register file and its LED scanner.
package regfile_pkg;

    localparam int unsigned DEF_ADDR_W = 2;
    localparam int unsigned DEF_DATA_W = 4;
    localparam int unsigned RD_DATA_W  = 8;
    localparam int unsigned LED_W      = 8;
    localparam int unsigned LED_ALIVE  = 7;
    localparam int unsigned LED_BUSY   = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_ADDR = 3'd1,
        ST_SAMPLE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Down-counter width able to hold HOLD_CYCLES-1 (always at least one bit).
    function automatic int unsigned timer_width(input int unsigned hold_cycles);
        return (hold_cycles + 1 > 2) ? $clog2(hold_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/regfile_scanner_hold_timer.sv
// Loadable down-counter that saturates at zero; zero flags the end of a hold window.
module hold_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/regfile_scanner.sv
// Walks the register file read port over every register and shows each
// sampled address/data pair on the board LEDs for a fixed hold time.
module regfile_scanner
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    input  logic                 stop,
    input  logic                 pause,
    output logic [ADDR_W-1:0]    read_addr,
    input  logic [RD_DATA_W-1:0] read_data,
    output logic                 busy,
    output logic                 done,
    output logic [LED_W-1:0]     LED
);

    localparam int unsigned       TMR_W    = timer_width(HOLD_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [TMR_W-1:0]  HOLD_RELOAD = TMR_W'(HOLD_CYCLES - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] read_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              cont_q;
    logic              stop_req_q;
    logic [LED_W-1:0]  led_q;

    logic tmr_load;
    logic tmr_en;
    logic tmr_zero;

    // Upper read-data bits carry nothing the LEDs can show.
    logic unused_rd_hi;
    assign unused_rd_hi = ^read_data[RD_DATA_W-1:DATA_W];

    assign tmr_load = (state_q == ST_SAMPLE);
    assign tmr_en   = (state_q == ST_HOLD) && !pause;

    hold_timer #(
        .W (TMR_W)
    ) u_hold_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (HOLD_RELOAD),
        .en       (tmr_en),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            read_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cont_q      <= 1'b0;
            stop_req_q  <= 1'b0;
            led_q       <= '0;
        end else begin
            led_q[LED_ALIVE] <= 1'b1;
            done_q           <= 1'b0;
            // A stop request is remembered until the pass it belongs to ends.
            if (busy_q && stop) begin
                stop_req_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q         <= ST_SET_ADDR;
                        idx_q           <= '0;
                        busy_q          <= 1'b1;
                        led_q[LED_BUSY] <= 1'b1;
                        cont_q          <= continuous;
                        stop_req_q      <= 1'b0;
                    end
                end
                ST_SET_ADDR: begin
                    read_addr_q <= idx_q;
                    state_q     <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    led_q[DATA_W-1:0]               <= read_data[DATA_W-1:0];
                    led_q[DATA_W+ADDR_W-1 -: ADDR_W] <= read_addr_q;
                    state_q                          <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!pause && tmr_zero) begin
                        if (idx_q != LAST_IDX) begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= ST_SET_ADDR;
                        end else if (cont_q && !stop_req_q && !stop) begin
                            idx_q   <= '0;
                            state_q <= ST_SET_ADDR;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    busy_q          <= 1'b0;
                    led_q[LED_BUSY] <= 1'b0;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_addr = read_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign LED       = led_q;

endmodule

// File: tb/tb_regfile_scanner.sv
// Bench for regfile_scanner: randomized register contents and control timing
// compared against a display timeline built from the scanner's rules.
`timescale 1ns/1ps
module tb_regfile_scanner;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned HOLD   = 3;
    localparam int unsigned NREG   = 4;
    localparam int          PERIOD = 2 + HOLD;

    logic              clk = 1'b0;
    logic              reset, start, continuous, stop, pause;
    logic [ADDR_W-1:0] read_addr;
    logic [7:0]        read_data;
    logic              busy, done;
    logic [7:0]        LED;

    logic [7:0] rf [NREG];
    logic [3:0] snap [NREG];

    int n_checks, n_fail;

    int seg_val[$], seg_len[$], exp_val[$], exp_len[$];
    int exp_total, done_cnt, done_at, led6_bad, disp_model;
    bit timed_out;
    int h_pause_at, h_pause_len, h_wr_at, h_wr_reg, h_stop_at;
    logic [7:0] h_wr_val;

    always #5 clk = ~clk;

    assign read_data = rf[read_addr];

    regfile_scanner #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .stop       (stop),
        .pause      (pause),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .LED        (LED)
    );

    function automatic void clear_hooks();
        h_pause_at = -1; h_pause_len = 0; h_wr_at = -1; h_wr_reg = 0; h_wr_val = 8'h00; h_stop_at = -1;
    endfunction

    function automatic void rand_rf();
        for (int k = 0; k < NREG; k++) rf[k] = 8'($urandom);
    endfunction

    function automatic void snap_rf();
        for (int k = 0; k < NREG; k++) snap[k] = rf[k][3:0];
    endfunction

    // Expected timeline: run-length list of LED[5:0] values while busy.
    function automatic void exp_push(input int val, input int len);
        exp_total += len;
        if (exp_val.size() != 0 && exp_val[exp_val.size()-1] == val)
            exp_len[exp_len.size()-1] += len;
        else begin
            exp_val.push_back(val);
            exp_len.push_back(len);
        end
    endfunction

    function automatic void exp_start();
        exp_val.delete(); exp_len.delete(); exp_total = 0;
        exp_push(disp_model, 2);
    endfunction

    // One pass: each register shown PERIOD cycles; the last one of the scan
    // leaves busy one cycle early (DONE), pause cycles stretch one register.
    function automatic void add_pass(input bit last, input int pause_reg, input int pause_len);
        for (int k = 0; k < NREG; k++)
            exp_push(k * 16 + int'(snap[k]),
                     ((last && k == NREG - 1) ? PERIOD - 1 : PERIOD) + ((k == pause_reg) ? pause_len : 0));
    endfunction

    // Starts a scan and records the LED timeline until the first idle cycle after done.
    task automatic run_scan(input bit cont, input bit hold_start, input int budget);
        int v;
        seg_val.delete(); seg_len.delete();
        done_cnt = 0; done_at = -1; led6_bad = 0; timed_out = 0;
        @(negedge clk);
        start = 1'b1; continuous = cont; pause = 1'b0; stop = 1'b0;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clk);
            if (!hold_start) start = 1'b0;
            if (cyc >= budget) begin timed_out = 1'b1; break; end
            if (LED[6] !== busy) led6_bad++;
            if (busy === 1'b1) begin
                v = int'(LED[5:0]);
                if (seg_val.size() == 0 || seg_val[seg_val.size()-1] != v) begin
                    seg_val.push_back(v); seg_len.push_back(1);
                end else seg_len[seg_len.size()-1]++;
            end
            if (done === 1'b1) begin done_cnt++; done_at = cyc; end
            else if (done_cnt > 0 && busy !== 1'b1) break;
            if (cyc == h_pause_at) pause = 1'b1;
            if (cyc == h_pause_at + h_pause_len) pause = 1'b0;
            if (cyc == h_wr_at) rf[h_wr_reg] = h_wr_val;
            stop = (cyc == h_stop_at);
        end
        pause = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (LED !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || read_addr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: LED=%h busy=%b done=%b addr=%0d, expected LED=00 busy=0 done=0 addr=0", LED, busy, done, read_addr);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (LED !== 8'h80 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alive: LED=%h busy=%b, expected LED=80 busy=0", LED, busy);
        end
        disp_model = 0;
    endtask

    task automatic test_single_pass();
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                rf[0] = 8'h93; rf[1] = 8'h0A; rf[2] = 8'hE5; rf[3] = 8'h4F;
            end else rand_rf();
            clear_hooks(); snap_rf(); exp_start(); add_pass(1'b1, -1, 0);
            run_scan(1'b0, 1'b0, 200);
            n_checks++;
            if (timed_out || done_cnt !== 1) begin
                n_fail++; $display("FAIL single%0d_done: pulses=%0d timeout=%0d, expected 1 pulse", it, done_cnt, timed_out);
            end
            n_checks++;
            if (seg_val.size() !== exp_val.size()) begin
                n_fail++; $display("FAIL single%0d_segcount: got %0d segments, expected %0d", it, seg_val.size(), exp_val.size());
            end
            for (int i = 0; i < exp_val.size() && i < seg_val.size(); i++) begin
                n_checks++;
                if (seg_val[i] !== exp_val[i] || seg_len[i] !== exp_len[i]) begin
                    n_fail++; $display("FAIL single%0d_seg%0d: got %02h x%0d, expected %02h x%0d", it, i, seg_val[i], seg_len[i], exp_val[i], exp_len[i]);
                end
            end
            n_checks++;
            if (done_at !== exp_total - 1 || led6_bad !== 0) begin
                n_fail++; $display("FAIL single%0d_timing: done at %0d led6_bad=%0d, expected %0d and 0", it, done_at, led6_bad, exp_total - 1);
            end
            disp_model = exp_val[exp_val.size()-1];
            n_checks++;
            if (LED !== (8'h80 | 8'(disp_model)) || busy !== 1'b0 || read_addr !== 2'd3) begin
                n_fail++; $display("FAIL single%0d_final: LED=%h busy=%b addr=%0d, expected LED=%h busy=0 addr=3", it, LED, busy, read_addr, 8'h80 | 8'(disp_model));
            end
        end
    endtask

    task automatic test_pause();
        int preg, plen, pat;
        for (int it = 0; it < 5; it++) begin
            rand_rf(); clear_hooks();
            case (it)
                0: begin preg = 2; plen = 10; pat = 2 + PERIOD * 2; end
                1: begin preg = -1; plen = 1; pat = 0; end
                2: begin preg = -1; plen = 2; pat = 2 + HOLD; end
                default: begin
                    preg = int'($urandom_range(NREG - 1, 0)); plen = int'($urandom_range(12, 1)); pat = 2 + PERIOD * preg;
                end
            endcase
            h_pause_at = pat; h_pause_len = plen;
            snap_rf(); exp_start(); add_pass(1'b1, preg, plen);
            run_scan(1'b0, 1'b0, 200);
            n_checks++;
            if (timed_out || done_cnt !== 1) begin
                n_fail++; $display("FAIL pause%0d_done: pulses=%0d timeout=%0d, expected 1 pulse", it, done_cnt, timed_out);
            end
            n_checks++;
            if (seg_val.size() !== exp_val.size()) begin
                n_fail++; $display("FAIL pause%0d_segcount: got %0d segments, expected %0d", it, seg_val.size(), exp_val.size());
            end
            for (int i = 0; i < exp_val.size() && i < seg_val.size(); i++) begin
                n_checks++;
                if (seg_val[i] !== exp_val[i] || seg_len[i] !== exp_len[i]) begin
                    n_fail++; $display("FAIL pause%0d_seg%0d: got %02h x%0d, expected %02h x%0d", it, i, seg_val[i], seg_len[i], exp_val[i], exp_len[i]);
                end
            end
            disp_model = exp_val[exp_val.size()-1];
        end
    endtask

    task automatic test_stop();
        // Case 0: stop during reg1 of the first pass; case 1: stop on the last-register advance edge of pass 2.
        for (int it = 0; it < 2; it++) begin
            rand_rf(); clear_hooks();
            h_stop_at = (it == 0) ? 2 + PERIOD * 1 : 2 + PERIOD * (2 * NREG - 1) + (HOLD - 1);
            snap_rf(); exp_start();
            if (it == 1) add_pass(1'b0, -1, 0);
            add_pass(1'b1, -1, 0);
            run_scan(1'b1, 1'b0, 300);
            n_checks++;
            if (timed_out || done_cnt !== 1) begin
                n_fail++; $display("FAIL stop%0d_done: pulses=%0d timeout=%0d, expected 1 pulse", it, done_cnt, timed_out);
            end
            n_checks++;
            if (seg_val.size() !== exp_val.size()) begin
                n_fail++; $display("FAIL stop%0d_segcount: got %0d segments, expected %0d", it, seg_val.size(), exp_val.size());
            end
            for (int i = 0; i < exp_val.size() && i < seg_val.size(); i++) begin
                n_checks++;
                if (seg_val[i] !== exp_val[i] || seg_len[i] !== exp_len[i]) begin
                    n_fail++; $display("FAIL stop%0d_seg%0d: got %02h x%0d, expected %02h x%0d", it, i, seg_val[i], seg_len[i], exp_val[i], exp_len[i]);
                end
            end
            disp_model = exp_val[exp_val.size()-1];
            n_checks++;
            if (LED !== (8'h80 | 8'(disp_model)) || busy !== 1'b0) begin
                n_fail++; $display("FAIL stop%0d_final: LED=%h busy=%b, expected LED=%h busy=0", it, LED, busy, 8'h80 | 8'(disp_model));
            end
        end
    endtask

    task automatic test_write_during_hold();
        rand_rf(); rf[1] = 8'h0A; clear_hooks();
        h_wr_at = 2 + PERIOD * 1; h_wr_reg = 1; h_wr_val = {4'($urandom), 4'h7};
        h_stop_at = 2 + PERIOD * (NREG + 2);
        snap_rf(); exp_start(); add_pass(1'b0, -1, 0);
        snap[1] = 4'h7; add_pass(1'b1, -1, 0);
        run_scan(1'b1, 1'b0, 300);
        n_checks++;
        if (timed_out || done_cnt !== 1) begin
            n_fail++; $display("FAIL write_done: pulses=%0d timeout=%0d, expected 1 pulse", done_cnt, timed_out);
        end
        n_checks++;
        if (seg_val.size() !== exp_val.size()) begin
            n_fail++; $display("FAIL write_segcount: got %0d segments, expected %0d", seg_val.size(), exp_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < seg_val.size(); i++) begin
            n_checks++;
            if (seg_val[i] !== exp_val[i] || seg_len[i] !== exp_len[i]) begin
                n_fail++; $display("FAIL write_seg%0d: got %02h x%0d, expected %02h x%0d", i, seg_val[i], seg_len[i], exp_val[i], exp_len[i]);
            end
        end
        disp_model = exp_val[exp_val.size()-1];
    endtask

    task automatic test_reset_mid_scan();
        rand_rf(); clear_hooks();
        @(negedge clk); start = 1'b1; continuous = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (2 + PERIOD * 2 + 1) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || LED[5:4] !== 2'd2) begin
            n_fail++; $display("FAIL midreset_pre: busy=%b LED addr=%0d, expected busy=1 addr=2", busy, LED[5:4]);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (LED !== 8'h00 || read_addr !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: LED=%h addr=%0d busy=%b done=%b, expected 00/0/0/0", LED, read_addr, busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (LED !== 8'h80) begin
            n_fail++; $display("FAIL midreset_alive: LED=%h, expected 80", LED);
        end
        disp_model = 0;
        snap_rf(); exp_start(); add_pass(1'b1, -1, 0);
        run_scan(1'b0, 1'b0, 200);
        n_checks++;
        if (timed_out || done_cnt !== 1) begin
            n_fail++; $display("FAIL midreset_done: pulses=%0d timeout=%0d, expected 1 pulse", done_cnt, timed_out);
        end
        n_checks++;
        if (seg_val.size() !== exp_val.size()) begin
            n_fail++; $display("FAIL midreset_segcount: got %0d segments, expected %0d", seg_val.size(), exp_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < seg_val.size(); i++) begin
            n_checks++;
            if (seg_val[i] !== exp_val[i] || seg_len[i] !== exp_len[i]) begin
                n_fail++; $display("FAIL midreset_seg%0d: got %02h x%0d, expected %02h x%0d", i, seg_val[i], seg_len[i], exp_val[i], exp_len[i]);
            end
        end
        disp_model = exp_val[exp_val.size()-1];
    endtask

    task automatic test_back_to_back();
        int waited;
        bit seen;
        rand_rf(); clear_hooks();
        snap_rf(); exp_start(); add_pass(1'b1, -1, 0);
        run_scan(1'b0, 1'b1, 200);
        n_checks++;
        if (timed_out || done_cnt !== 1) begin
            n_fail++; $display("FAIL b2b_done: pulses=%0d timeout=%0d, expected 1 pulse", done_cnt, timed_out);
        end
        n_checks++;
        if (seg_val.size() !== exp_val.size()) begin
            n_fail++; $display("FAIL b2b_segcount: got %0d segments, expected %0d", seg_val.size(), exp_val.size());
        end
        for (int i = 0; i < exp_val.size() && i < seg_val.size(); i++) begin
            n_checks++;
            if (seg_val[i] !== exp_val[i] || seg_len[i] !== exp_len[i]) begin
                n_fail++; $display("FAIL b2b_seg%0d: got %02h x%0d, expected %02h x%0d", i, seg_val[i], seg_len[i], exp_val[i], exp_len[i]);
            end
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_restart: busy=%b one cycle after idle, expected 1", busy);
        end
        seen = 1'b0; waited = 0;
        while (!seen && waited < 100) begin
            @(negedge clk);
            waited++;
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || waited !== PERIOD * NREG) begin
            n_fail++; $display("FAIL b2b_second_pass: done seen=%0d after %0d cycles, expected 1 after %0d", seen, waited, PERIOD * NREG);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || LED !== (8'h80 | 8'(exp_val[exp_val.size()-1]))) begin
            n_fail++; $display("FAIL b2b_final: busy=%b LED=%h, expected busy=0 LED=%h", busy, LED, 8'h80 | 8'(exp_val[exp_val.size()-1]));
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0; pause = 1'b0;
        disp_model = 0; exp_total = 0;
        clear_hooks();
        for (int k = 0; k < NREG; k++) rf[k] = 8'h00;
        test_reset();
        test_single_pass();
        test_pause();
        test_stop();
        test_write_during_hold();
        test_reset_mid_scan();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
